// File: rtl/dcp_pkg.sv
// Shared definitions for the haze-removal pipeline output stage.
//   PIX_W        width of one recovered colour channel
//   AXIS_DATA_W  width of the AXI4-Stream data bus
//   pack_rgb     places R,G,B into the 32-bit beat format {8'h00, R, G, B}
package dcp_pkg;

    localparam int PIX_W       = 8;
    localparam int AXIS_DATA_W = 32;

    function automatic logic [AXIS_DATA_W-1:0] pack_rgb(
        input logic [PIX_W-1:0] r,
        input logic [PIX_W-1:0] g,
        input logic [PIX_W-1:0] b
    );
        return {8'h00, r, g, b};
    endfunction

endpackage

// File: rtl/dcp_axis_frame_tx_if.sv
// AXI4-Stream bus between the frame transmitter and the DMA S2MM channel.
//   tdata  beat payload {8'h00, R, G, B}
//   tvalid beat valid (master)
//   tlast  last beat of a frame (master)
//   tready sink ready (slave)
import dcp_pkg::*;

interface dcp_axis_frame_tx_if;
    logic [AXIS_DATA_W-1:0] tdata;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dcp_sync_fifo.sv
// Single-clock FIFO with a registered read port, suitable for block-RAM mapping.
//   clk_i      clock
//   rst_n_i    synchronous active-low reset (pointers, count, read register)
//   wr_en_i    write request, ignored while full
//   wr_data_i  write data
//   rd_en_i    read request, ignored while empty; data appears in rd_data_o after the edge
//   rd_data_o  registered read data, holds its value while no read occurs
//   full_o     DEPTH entries stored
//   empty_o    no entries stored
module dcp_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == (AW+1)'(0));
    assign wr_ok_s   = wr_en_i & ~full_o;
    assign rd_ok_s   = rd_en_i & ~empty_o;
    assign rd_data_o = rd_data_q;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            mem[wptr_q] <= wr_data_i;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (wr_ok_s) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_ok_s) begin
                rptr_q    <= rptr_q + AW'(1);
                rd_data_q <= mem[rptr_q];
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dcp_axis_frame_tx.sv
// AXI4-Stream frame transmitter: buffers the valid-only recovered-pixel stream and
// drives it out as a handshaked stream with TLAST on the last pixel of each frame.
//   ACLK, ARESETn     clock, synchronous active-low reset
//   enable            input gate; in_valid is ignored while low
//   in_valid          pixel strobe, no backpressure
//   in_r/in_g/in_b    pixel channels
//   m_axis            AXI4-Stream master (tdata/tvalid/tlast out, tready in)
//   fifo_level        occupancy including the output register
//   overflow          sticky, set the cycle after a pixel is dropped
//   o_frame_intr      one-cycle pulse after each TLAST handshake
module dcp_axis_frame_tx
    import dcp_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        enable,
    input  logic                        in_valid,
    input  logic [PIX_W-1:0]            in_r,
    input  logic [PIX_W-1:0]            in_g,
    input  logic [PIX_W-1:0]            in_b,
    dcp_axis_frame_tx_if.master         m_axis,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        o_frame_intr
);
    localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W     = AXIS_DATA_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             intr_q, intr_d;
    logic             out_valid_q, out_valid_d;

    logic             push_s;
    logic             accept_s;
    logic             hs_s;
    logic             last_s;
    logic             fifo_rd_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [ENT_W-1:0] fifo_rd_data_s;

    assign push_s   = in_valid & enable;
    assign last_s   = (cnt_q == CNT_W'(FRAME_PIX - 1));
    // Fullness is judged on the registered level, so a same-cycle pop never makes room.
    assign accept_s = push_s & (level_q != LVL_W'(FIFO_DEPTH)) & ~fifo_full_s;
    assign hs_s     = out_valid_q & m_axis.tready;
    // The FIFO read register doubles as the output register: refill it when it is
    // empty or being consumed this cycle.
    assign fifo_rd_s = ~fifo_empty_s & (~out_valid_q | m_axis.tready);

    dcp_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (ACLK),
        .rst_n_i   (ARESETn),
        .wr_en_i   (accept_s),
        .wr_data_i ({last_s, pack_rgb(in_r, in_g, in_b)}),
        .rd_en_i   (fifo_rd_s),
        .rd_data_o (fifo_rd_data_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    // Next-state for pixel counter, level, overflow, interrupt and output valid.
    always_comb begin
        cnt_d       = cnt_q;
        level_d     = level_q;
        ovf_d       = ovf_q;
        intr_d      = 1'b0;
        out_valid_d = out_valid_q;

        // Counter advances on every push, dropped or not, so frame alignment survives overflow.
        if (push_s) begin
            cnt_d = last_s ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (push_s && !accept_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        case ({accept_s, hs_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (fifo_rd_s) begin
            out_valid_d = 1'b1;
        end else if (hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        intr_d = hs_s & fifo_rd_data_s[ENT_W-1];
    end

    // State registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cnt_q       <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            intr_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            intr_q      <= intr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign m_axis.tdata  = fifo_rd_data_s[AXIS_DATA_W-1:0];
    assign m_axis.tlast  = fifo_rd_data_s[ENT_W-1];
    assign m_axis.tvalid = out_valid_q;
    assign fifo_level    = level_q;
    assign overflow      = ovf_q;
    assign o_frame_intr  = intr_q;

endmodule

// File: tb/tb_dcp_axis_frame_tx.sv
// Self-checking bench for dcp_axis_frame_tx with a 4x4 frame and an 8-entry buffer.
module tb_dcp_axis_frame_tx;
    import dcp_pkg::*;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int DEPTH = 8;
    localparam int FPIX  = W * H;

    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic       enable = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_r = 8'd0;
    logic [7:0] in_g = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       o_frame_intr;

    dcp_axis_frame_tx_if axis ();

    dcp_axis_frame_tx #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_r         (in_r),
        .in_g         (in_g),
        .in_b         (in_b),
        .m_axis       (axis.master),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .o_frame_intr (o_frame_intr)
    );

    always #5 ACLK = ~ACLK;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] sb[$];
    int          lvl_m = 0;
    bit          ovf_m = 1'b0;
    int          cnt_m = 0;
    int          beats = 0;
    int          intr_cnt = 0;
    int          pushed = 0;
    logic [7:0]  pix = 8'd0;
    bit          pv = 1'b0;
    logic [31:0] pd = 32'd0;
    logic        pl = 1'b0;
    bit          phs = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Set up the next input beat (valid or idle).
    task automatic drv(input bit v);
        in_valid = v;
        in_r = pix;
        in_g = pix + 8'd1;
        in_b = pix + 8'd2;
        if (v) pix = pix + 8'd1;
    endtask

    // One clock: score the handshake and push, advance the model, check registered outputs.
    task automatic cycle();
        bit          hs;
        bit          push;
        bit          acc;
        bit          el;
        logic [32:0] e;
        hs = axis.tvalid && axis.tready;
        el = 1'b0;
        if (hs) begin
            chk("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("tdata", 64'(axis.tdata), 64'(e[31:0]));
                chk("tlast", 64'(axis.tlast), 64'(e[32]));
                el = e[32];
                beats++;
                if (axis.tlast) chk("tlast_pos", 64'(beats % FPIX), 64'd0);
            end
        end
        push = in_valid && enable;
        acc  = push && (lvl_m < DEPTH);
        if (acc) sb.push_back({(cnt_m == FPIX - 1), pack_rgb(in_r, in_g, in_b)});
        if (push && !acc) ovf_m = 1'b1;
        if (push) cnt_m = (cnt_m == FPIX - 1) ? 0 : cnt_m + 1;
        if (acc) pushed++;
        lvl_m = lvl_m + int'(acc) - int'(hs);
        pv  = axis.tvalid;
        pd  = axis.tdata;
        pl  = axis.tlast;
        phs = hs;
        @(posedge ACLK);
        #1;
        chk("fifo_level", 64'(fifo_level), 64'(lvl_m));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        chk("frame_intr", 64'(o_frame_intr), 64'(hs && el));
        if (o_frame_intr) intr_cnt++;
        if (pv && !phs) begin
            chk("stall_valid", 64'(axis.tvalid), 64'd1);
            chk("stall_data", 64'(axis.tdata), 64'(pd));
            chk("stall_last", 64'(axis.tlast), 64'(pl));
        end
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        in_valid = 1'b0;
        axis.tready = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        chk("rst_tvalid", 64'(axis.tvalid), 64'd0);
        chk("rst_tdata", 64'(axis.tdata), 64'd0);
        chk("rst_tlast", 64'(axis.tlast), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_intr", 64'(o_frame_intr), 64'd0);
        sb.delete();
        lvl_m = 0;
        ovf_m = 1'b0;
        cnt_m = 0;
        beats = 0;
        pv = 1'b0;
        phs = 1'b0;
    endtask

    // Empty the block; rnd selects random TREADY, otherwise TREADY is held high.
    task automatic drain(input bit rnd);
        int n;
        n = 0;
        drv(1'b0);
        while ((sb.size() != 0 || axis.tvalid) && n < 300) begin
            axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_tvalid", 64'(axis.tvalid), 64'd0);
    endtask

    initial begin
        int b0;
        int n;
        axis.tready = 1'b0;
        do_reset();

        // 1: single frame, no backpressure, latency of first beat
        intr_cnt = 0;
        axis.tready = 1'b1;
        drv(1'b1);
        cycle();
        chk("lat_edge1", 64'(axis.tvalid), 64'd0);
        drv(1'b1);
        cycle();
        chk("lat_edge2", 64'(axis.tvalid), 64'd1);
        for (int i = 2; i < FPIX; i++) begin
            drv(1'b1);
            cycle();
        end
        drain(1'b0);
        chk("t1_beats", 64'(beats), 64'd16);
        chk("t1_intr", 64'(intr_cnt), 64'd1);

        // 2: random backpressure over three frames
        intr_cnt = 0;
        pushed = 0;
        b0 = beats;
        n = 0;
        while (pushed < 3 * FPIX && n < 2000) begin
            axis.tready = 1'($urandom_range(0, 1));
            drv((pushed < 3 * FPIX) && ($urandom_range(0, 3) != 0) && (lvl_m < DEPTH));
            cycle();
            n++;
        end
        drain(1'b1);
        chk("t2_beats", 64'(beats - b0), 64'd48);
        chk("t2_intr", 64'(intr_cnt), 64'd3);

        // 3: overflow with TREADY low
        axis.tready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drv(1'b1);
            cycle();
            if (i == 7) chk("t3_no_ovf_at8", 64'(overflow), 64'd0);
            if (i == 8) chk("t3_ovf_after9", 64'(overflow), 64'd1);
        end
        chk("t3_level_full", 64'(fifo_level), 64'd8);
        chk("t3_overflow", 64'(overflow), 64'd1);
        b0 = beats;
        drain(1'b0);
        chk("t3_beats", 64'(beats - b0), 64'd8);
        chk("t3_ovf_sticky", 64'(overflow), 64'd1);

        // 4: back-to-back frames
        do_reset();
        intr_cnt = 0;
        axis.tready = 1'b1;
        for (int i = 0; i < 2 * FPIX; i++) begin
            drv(1'b1);
            cycle();
        end
        drain(1'b0);
        chk("t4_beats", 64'(beats), 64'd32);
        chk("t4_intr", 64'(intr_cnt), 64'd2);

        // 5: reset after five beats, then a fresh frame
        axis.tready = 1'b1;
        beats = 0;
        n = 0;
        while (beats < 5 && n < 50) begin
            drv(1'b1);
            cycle();
            n++;
        end
        chk("t5_five_beats", 64'(beats), 64'd5);
        do_reset();
        intr_cnt = 0;
        axis.tready = 1'b1;
        for (int i = 0; i < FPIX; i++) begin
            drv(1'b1);
            cycle();
        end
        drain(1'b0);
        chk("t5_beats", 64'(beats), 64'd16);
        chk("t5_intr", 64'(intr_cnt), 64'd1);

        // 6: enable gating mid-frame
        intr_cnt = 0;
        beats = 0;
        axis.tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drv(1'b1);
            cycle();
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drv(1'b1);
            cycle();
        end
        chk("t6_level_held", 64'(fifo_level), 64'd6);
        enable = 1'b1;
        axis.tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drv(1'b1);
            cycle();
        end
        drain(1'b0);
        chk("t6_beats", 64'(beats), 64'd16);
        chk("t6_intr", 64'(intr_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
